// File: rtl/dac_sync_sched_if.sv
// Control, board-status and strobe bundle between the system sequencer and
// the trigger/LDAC scheduler.
interface dac_sync_sched_if #(
  parameter int N_BOARDS = 8
);
  logic                arm;
  logic                disarm;
  logic                clear_err;
  logic                ext_trig;
  logic                sw_trig;
  logic [N_BOARDS-1:0] setup_done;
  logic [N_BOARDS-1:0] board_ldac;
  logic [N_BOARDS-1:0] board_err;
  logic                trig_out;
  logic                ldac_shared;
  logic [1:0]          state;
  logic [N_BOARDS-1:0] err_latched;
  logic                trig_overrun;
  logic [31:0]         trig_count;
  logic [31:0]         ldac_count;

  modport master (
    output arm, disarm, clear_err, ext_trig, sw_trig, setup_done, board_ldac, board_err,
    input  trig_out, ldac_shared, state, err_latched, trig_overrun, trig_count, ldac_count
  );

  modport slave (
    input  arm, disarm, clear_err, ext_trig, sw_trig, setup_done, board_ldac, board_err,
    output trig_out, ldac_shared, state, err_latched, trig_overrun, trig_count, ldac_count
  );
endinterface

// File: rtl/dac_sync_sched.sv
// Shared trigger / LDAC scheduler for the shim DAC boards: gates both strobes on
// board readiness, spaces triggers, defers them around LDAC and halts on board error.
module dac_sync_sched #(
  parameter int N_BOARDS     = 8,
  parameter int LDAC_WIDTH   = 4,
  parameter int TRIG_HOLDOFF = 16
) (
  input logic             clk,
  input logic             rst,
  dac_sync_sched_if.slave bus
);
  localparam logic [1:0] S_WAIT_SETUP = 2'd0;
  localparam logic [1:0] S_IDLE       = 2'd1;
  localparam logic [1:0] S_ARMED      = 2'd2;
  localparam logic [1:0] S_HALT       = 2'd3;
  localparam int LW = $clog2(LDAC_WIDTH + 1);
  localparam int HW = (TRIG_HOLDOFF > 1) ? $clog2(TRIG_HOLDOFF) : 1;

  logic [1:0]          state_p1, state_p0;
  logic [LW-1:0]       ldac_cnt_p1, ldac_cnt_p0;
  logic [HW-1:0]       holdoff_p1;
  logic                pending_p1, pending_p0;
  logic                ext_trig_p1;
  logic                trig_out_p1;
  logic                ldac_shared_p1;
  logic                trig_overrun_p1;
  logic [N_BOARDS-1:0] err_latched_p1;
  logic [31:0]         trig_count_p1;
  logic [31:0]         ldac_count_p1;

  logic all_setup, any_err, run_now, run_nxt;
  logic ldac_start, ldac_busy_nxt;
  logic trig_req, trig_live, holdoff_zero, trig_issue, trig_drop;

  assign all_setup = &bus.setup_done;
  assign any_err   = |bus.board_err;

  // Stage p0: next-state, LDAC and trigger arbitration from current registers
  always_comb begin
    state_p0 = state_p1;
    case (state_p1)
      S_WAIT_SETUP: if (all_setup) state_p0 = S_IDLE;
      S_IDLE: begin
        if (any_err)         state_p0 = S_HALT;
        else if (!all_setup) state_p0 = S_WAIT_SETUP;
        else if (bus.arm)    state_p0 = S_ARMED;
      end
      S_ARMED: begin
        if (any_err || !all_setup) state_p0 = S_HALT;
        else if (bus.disarm)       state_p0 = S_IDLE;
      end
      default: if (bus.clear_err && !any_err) state_p0 = S_WAIT_SETUP;
    endcase
  end

  assign run_now = (state_p1 == S_IDLE) || (state_p1 == S_ARMED);
  assign run_nxt = (state_p0 == S_IDLE) || (state_p0 == S_ARMED);

  // A pulse never starts on a cycle that is leaving the running states
  assign ldac_start = run_now && run_nxt && (|bus.board_ldac) && (ldac_cnt_p1 == '0);

  always_comb begin
    ldac_cnt_p0 = '0;
    if (!run_nxt)                 ldac_cnt_p0 = '0;
    else if (ldac_start)          ldac_cnt_p0 = LW'(LDAC_WIDTH);
    else if (ldac_cnt_p1 != '0)   ldac_cnt_p0 = ldac_cnt_p1 - 1'b1;
  end

  // Blocking on next cycle's LDAC lets a deferred trigger land right as the pulse ends
  assign ldac_busy_nxt = (ldac_cnt_p0 != '0);
  assign trig_req      = (bus.ext_trig & ~ext_trig_p1) | bus.sw_trig;
  assign trig_live     = (state_p1 == S_ARMED) && (state_p0 == S_ARMED);
  assign holdoff_zero  = (holdoff_p1 == '0);
  assign trig_issue    = trig_live && (trig_req || pending_p1) && holdoff_zero && !ldac_busy_nxt;
  assign trig_drop     = trig_live && trig_req && (pending_p1 || !holdoff_zero);

  always_comb begin
    pending_p0 = pending_p1;
    if (!trig_live || trig_issue)    pending_p0 = 1'b0;
    else if (trig_req && holdoff_zero) pending_p0 = 1'b1;
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1        <= S_WAIT_SETUP;
      ldac_cnt_p1     <= '0;
      holdoff_p1      <= '0;
      pending_p1      <= 1'b0;
      ext_trig_p1     <= 1'b0;
      trig_out_p1     <= 1'b0;
      ldac_shared_p1  <= 1'b0;
      trig_overrun_p1 <= 1'b0;
      err_latched_p1  <= '0;
      trig_count_p1   <= '0;
      ldac_count_p1   <= '0;
    end else begin
      state_p1       <= state_p0;
      ldac_cnt_p1    <= ldac_cnt_p0;
      pending_p1     <= pending_p0;
      ext_trig_p1    <= bus.ext_trig;
      trig_out_p1    <= trig_issue;
      ldac_shared_p1 <= ldac_busy_nxt;
      if (trig_issue)          holdoff_p1 <= HW'(TRIG_HOLDOFF - 1);
      else if (!holdoff_zero)  holdoff_p1 <= holdoff_p1 - 1'b1;
      if (trig_drop)  trig_overrun_p1 <= 1'b1;
      if (trig_issue) trig_count_p1   <= trig_count_p1 + 32'd1;
      if (ldac_start) ldac_count_p1   <= ldac_count_p1 + 32'd1;
      if (state_p1 == S_HALT && state_p0 == S_WAIT_SETUP) err_latched_p1 <= '0;
      else if (run_now)                                  err_latched_p1 <= err_latched_p1 | bus.board_err;
    end
  end

  assign bus.trig_out     = trig_out_p1;
  assign bus.ldac_shared  = ldac_shared_p1;
  assign bus.state        = state_p1;
  assign bus.err_latched  = err_latched_p1;
  assign bus.trig_overrun = trig_overrun_p1;
  assign bus.trig_count   = trig_count_p1;
  assign bus.ldac_count   = ldac_count_p1;
endmodule

// File: doc/dac_sync_sched.md
# dac_sync_sched

System-level trigger and LDAC scheduler for the shim DAC boards. It sits above the per-board DAC controllers and owns the two shared strobes they all see:
- the trigger that releases TRIG_WAIT commands;
- the shared LDAC that latches every board's written registers.

It gates both strobes on board readiness, enforces trigger hold-off, keeps triggers from coinciding with LDAC, and halts everything on the first board error.

## Interface
Parameters:
- N_BOARDS, 8: number of DAC board controllers served.
- LDAC_WIDTH, 4: cycles `ldac_shared` stays high per pulse (≥1).
- TRIG_HOLDOFF, 16: minimum cycles from one `trig_out` pulse to the next (≥1).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  1-cycle pulse: request IDLE→ARMED.
- disarm  in  1  1-cycle pulse: request ARMED→IDLE.
- clear_err  in  1  1-cycle pulse: leave HALT.
- ext_trig  in  1  external trigger, already synchronous to clk, level; the rising edge is the event.
- sw_trig  in  1  1-cycle software trigger.
- setup_done  in  N_BOARDS  per-board setup-complete.
- board_ldac  in  N_BOARDS  per-board LDAC request pulses.
- board_err  in  N_BOARDS  per-board OR of error flags.
- trig_out  out  1  1-cycle trigger to all boards.
- ldac_shared  out  1  shared LDAC strobe.
- state  out  2  0 WAIT_SETUP, 1 IDLE, 2 ARMED, 3 HALT.
- err_latched  out  N_BOARDS  sticky board error capture.
- trig_overrun  out  1  sticky: a trigger was dropped.
- trig_count  out  32  triggers issued.
- ldac_count  out  32  LDAC pulses issued.

## Operation
- Reset values:
  - `state` = WAIT_SETUP.
  - All other outputs 0.
  - Internal hold-off counter, LDAC counter, pending flag and ext_trig edge register all 0.
- State machine, evaluated in priority order per cycle:
  - WAIT_SETUP:
    - &setup_done → IDLE.
  - IDLE:
    - |board_err → HALT.
    - Any setup_done low → WAIT_SETUP.
    - Else arm → ARMED.
  - ARMED:
    - |board_err or any setup_done low → HALT.
    - Else disarm → IDLE.
  - HALT:
    - clear_err with board_err == 0 → WAIT_SETUP.
    - clear_err while any board_err is set is ignored.
- err_latched:
  - Sets with board_err (bitwise OR) while in IDLE or ARMED.
  - Cleared on a successful HALT exit.
- Trigger path (active only in ARMED):
  - Request: trig_req = (ext_trig & ~ext_trig_q) | sw_trig. Simultaneous edge and sw_trig count as one request.
  - Issue when a request or pending trigger is present, the hold-off counter is 0, ldac_shared is low, and no LDAC pulse starts this cycle.
  - On issue: trig_out pulses 1 cycle, the hold-off counter loads TRIG_HOLDOFF-1, trig_count increments (wraps at 2^32), and pending clears.
  - A request blocked only by LDAC (current or starting) sets pending.
  - A request blocked by hold-off, or a request while pending is already set, is dropped and sets trig_overrun.
  - Leaving ARMED clears pending; the hold-off counter keeps counting down.
- LDAC path (active in IDLE and ARMED):
  - If |board_ldac and the LDAC counter is 0, ldac_shared goes high for LDAC_WIDTH cycles and ldac_count increments (wraps).
  - board_ldac during an active pulse is absorbed; it is not counted and does not extend the pulse.
- Entering HALT or WAIT_SETUP, including from mid-pulse:
  - Force ldac_shared low and clear the LDAC counter on the transition cycle.
  - Clear pending.
  - trig_out never asserts in these states.
- trig_out and ldac_shared are never high in the same cycle.
- trig_overrun and the counters clear only on rst.

## Timing
- All outputs are registered.
- trig_req in cycle N → trig_out high in N+1 when issue is permitted.
- board_ldac in cycle N → ldac_shared high in cycles N+1 … N+LDAC_WIDTH.
- Pending trigger: issued in the first cycle after ldac_shared falls, i.e. trig_out in the cycle after the last high ldac_shared cycle (hold-off permitting).
- Consecutive triggers: earliest spacing is TRIG_HOLDOFF cycles, trig_out to trig_out.
- State transitions take effect the cycle after the qualifying input.
- Effect of an error: board_err in cycle N → state = HALT in N+1, and ldac_shared/trig_out are low from N+1.
- rst is asynchronous: all registers go to reset values immediately, including mid-pulse.

## Test plan
- Bring-up:
  - Stimulus: setup_done ramps 0x00→0xFF, then arm.
  - Response: state 0→1→2, each one cycle after its cause.
- Trigger hold-off:
  - Stimulus: sw_trig at t=0, 10, 16 with TRIG_HOLDOFF=16.
  - Response: trig_out at t=1 and t=17; the t=10 request is dropped; trig_overrun=1; trig_count=2.
- LDAC deferral:
  - Stimulus: board_ldac[3] at t=0, sw_trig at t=2, LDAC_WIDTH=4.
  - Response: ldac_shared high t=1..4; trig_out at t=5.
- Simultaneous events:
  - Stimulus: board_ldac and ext_trig rising edge in the same cycle.
  - Response: ldac_shared first, trigger pending, trig_out after the pulse; ldac_count=1, trig_count=1.
- Error halt:
  - Stimulus: board_err[5] mid-LDAC-pulse while ARMED.
  - Response: next cycle state=3, ldac_shared=0, err_latched=0x20. clear_err with board_err still high → stays HALT; once board_err clears, clear_err → WAIT_SETUP.
- Async reset:
  - Stimulus: rst asserted mid-pulse between clock edges.
  - Response: outputs clear without waiting for a clock edge; trig_count=0, state=0.
